i2c_share_arbiter: RTL and testbench
====================================

// Module: i2c_share_arbiter
// PURPOSE
//  Shares the single I2C write master between N_REQ configuration sequencers
//  (e.g. the HDMI transmitter config queue and the audio codec config queue).
//  Captures each sequencer's 3-byte write request, grants the master round-robin,
//  issues a one-cycle i2c_start, and tracks the master's busy flag until the
//  transfer completes. Sits between the config sequencers and the I2C master.
// PARAMETERS
//  N_REQ          2    number of requesters (2..8)
//  BUSY_WAIT_MAX  255  cycles to wait for i2c_busy to rise after i2c_start before error
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  rst          in   1        asynchronous, active-low reset
//  req_start    in   N_REQ    per-requester 1-cycle write request pulse
//  req_address  in   7*N_REQ  7-bit device address, requester i at [7i+6:7i]
//  req_data_0   in   8*N_REQ  register byte, requester i at [8i+7:8i]
//  req_data_1   in   8*N_REQ  value byte, requester i at [8i+7:8i]
//  req_busy     out  N_REQ    high from accepted request until its completion
//  req_done     out  N_REQ    1-cycle pulse when requester's transfer completes
//  req_error    out  N_REQ    1-cycle pulse (with req_done) on busy-wait timeout
//  i2c_busy     in   1        busy flag from I2C master
//  i2c_address  out  7        address to master, held stable while granted
//  i2c_data_0   out  8        first data byte to master
//  i2c_data_1   out  8        second data byte to master
//  i2c_start    out  1        1-cycle start pulse to master
//  grant_id     out  3        index of current/last granted requester
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, state IDLE, pending=0, rr pointer=N_REQ-1
//   (so requester 0 has first priority). In-flight master transfer not aborted.
//  Capture: at edge where req_start[i]=1 and req_busy[i]=0, latch the request into
//   slot i, set pending[i]; req_busy[i]=1 after that edge. req_start[i] while
//   req_busy[i]=1 is ignored (no overwrite, no queueing).
//  FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//   IDLE: if any pending (registered value) and i2c_busy=0: pick first pending index
//    after rr pointer (wrap at N_REQ), load i2c_address/data, grant_id, pointer=index;
//    go ISSUE with i2c_start=1. If i2c_busy=1, stay IDLE (covers post-reset).
//   ISSUE: i2c_start=1 for exactly this one cycle; clear timer; go WAIT_BUSY.
//   WAIT_BUSY: i2c_busy=1 -> WAIT_DONE. Else timer+1; when timer reaches
//    BUSY_WAIT_MAX-1: pulse req_done[g] and req_error[g], clear pending[g], req_busy[g]; IDLE.
//   WAIT_DONE: i2c_busy=0 -> pulse req_done[g], clear pending[g] and req_busy[g]; IDLE.
//  Latency: request accepted at edge E0 -> i2c_start high for cycle E1..E2 if idle.
//  Completion edge: req_busy[g] falls, req_done[g] high one cycle; req_start[g] at
//   that same edge is still ignored (busy was 1); a new request is accepted one edge later.
//  i2c_address/data/grant_id hold last grant values in IDLE; change only on grant.
//  Fairness: with all requesters pending, grants rotate 0,1,..,N_REQ-1,0,...
//  Timer width = clog2(BUSY_WAIT_MAX+1); no overflow (saturates at compare).
// STRUCTURE
//  Shared package/include i2c_cfg_defs: FSM state encodings, I2C_ADDR_W=7,
//   I2C_DATA_W=8, HDMI_TX_ADDR=7'h72.
//  Sub-module i2c_rr_pick: combinational round-robin picker (pending, pointer ->
//   valid, index). Slots, FSM, timer in top.
// TESTING
//  Single req: req_start[0] with addr 72, d0 15, d1 00; busy rises 3 cycles later, falls
//   after 20 -> i2c_start 1 cycle at E1, outputs 72/15/00, req_done[0] on busy fall.
//  Contention: req_start[0]/[1] same cycle (0:72/41/10, 1:1A/02/55) -> 0 served first,
//   then 1; exactly two i2c_start pulses, never while i2c_busy=1.
//  Rotation: both requesters re-request on each done for 6 transfers -> grant_id 0,1,0,1,0,1.
//  Timeout: BUSY_WAIT_MAX=8, i2c_busy held 0 -> req_done[0] and req_error[0] at cycle
//   E1+9, FSM back in IDLE, next pending request issued.
//  Ignore-while-busy: second req_start[0] (d0 AA) during its transfer -> master never
//   sees AA; only one req_done[0].
//  Reset mid-transfer: rst low in WAIT_DONE -> outputs 0 immediately; with i2c_busy
//   still 1 after release, new request waits until busy falls before i2c_start.

Source files
------------

// File: rtl/i2c_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : i2c_cfg_defs
//  Description : Shared widths, device addresses and arbiter FSM encoding
//                for the I2C configuration-write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_cfg_defs;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam int GRANT_W    = 3;

    localparam logic [I2C_ADDR_W-1:0] HDMI_TX_ADDR = 7'h72;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_rr_pick
//  Description : Combinational round-robin picker; returns the first pending
//                index strictly after the pointer, wrapping at N_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_rr_pick
    import i2c_cfg_defs::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]   pending,
    input  logic [GRANT_W-1:0] pointer,
    output logic               valid,
    output logic [GRANT_W-1:0] index
);

    logic [7:0]       w_pend_ext;
    logic [GRANT_W:0] w_pos;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        w_pend_ext             = '0;
        w_pend_ext[N_REQ-1:0]  = pending;
        valid                  = 1'b0;
        index                  = '0;
        w_pos                  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_pos = {1'b0, pointer} + (GRANT_W+1)'(k);
            if (w_pos >= (GRANT_W+1)'(N_REQ)) begin
                w_pos = w_pos - (GRANT_W+1)'(N_REQ);
            end
            if (w_pend_ext[w_pos[GRANT_W-1:0]]) begin
                valid = 1'b1;
                index = w_pos[GRANT_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_share_arbiter
//  Description : Round-robin sharing of one I2C write master between N_REQ
//                configuration sequencers, with busy-rise timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_share_arbiter
    import i2c_cfg_defs::*;
#(
    parameter int N_REQ         = 2,
    parameter int BUSY_WAIT_MAX = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_start,
    input  logic [I2C_ADDR_W*N_REQ-1:0]   req_address,
    input  logic [I2C_DATA_W*N_REQ-1:0]   req_data_0,
    input  logic [I2C_DATA_W*N_REQ-1:0]   req_data_1,
    output logic [N_REQ-1:0]              req_busy,
    output logic [N_REQ-1:0]              req_done,
    output logic [N_REQ-1:0]              req_error,
    input  logic                          i2c_busy,
    output logic [I2C_ADDR_W-1:0]         i2c_address,
    output logic [I2C_DATA_W-1:0]         i2c_data_0,
    output logic [I2C_DATA_W-1:0]         i2c_data_1,
    output logic                          i2c_start,
    output logic [GRANT_W-1:0]            grant_id
);

    localparam int                   TIMER_W      = $clog2(BUSY_WAIT_MAX + 1);
    localparam logic [TIMER_W-1:0]   C_TIMER_LAST = TIMER_W'(BUSY_WAIT_MAX - 1);
    localparam logic [GRANT_W-1:0]   C_PTR_RESET  = GRANT_W'(N_REQ - 1);

    arb_state_t              r_state;
    logic [N_REQ-1:0]        r_pending;
    logic [N_REQ-1:0]        r_done;
    logic [N_REQ-1:0]        r_error;
    logic [I2C_ADDR_W-1:0]   r_slot_addr [N_REQ];
    logic [I2C_DATA_W-1:0]   r_slot_d0   [N_REQ];
    logic [I2C_DATA_W-1:0]   r_slot_d1   [N_REQ];
    logic [I2C_ADDR_W-1:0]   r_addr;
    logic [I2C_DATA_W-1:0]   r_d0;
    logic [I2C_DATA_W-1:0]   r_d1;
    logic                    r_start;
    logic [GRANT_W-1:0]      r_grant;
    logic [GRANT_W-1:0]      r_ptr;
    logic [TIMER_W-1:0]      r_timer;

    logic                    w_pick_valid;
    logic [GRANT_W-1:0]      w_pick_idx;
    logic [N_REQ-1:0]        w_capture;
    logic [N_REQ-1:0]        w_grant_onehot;
    logic [N_REQ-1:0]        w_clear;
    logic                    w_finish;
    logic                    w_timeout;
    logic [I2C_ADDR_W-1:0]   w_sel_addr;
    logic [I2C_DATA_W-1:0]   w_sel_d0;
    logic [I2C_DATA_W-1:0]   w_sel_d1;

    i2c_rr_pick #(
        .N_REQ   (N_REQ)
    ) u_pick (
        .pending (r_pending),
        .pointer (r_ptr),
        .valid   (w_pick_valid),
        .index   (w_pick_idx)
    );

    // A request already held in its slot blocks any new one from that requester.
    assign w_capture      = req_start & ~r_pending;
    assign w_grant_onehot = N_REQ'(1) << r_grant;
    assign w_finish       = (r_state == ST_WAIT_DONE) && !i2c_busy;
    assign w_timeout      = (r_state == ST_WAIT_BUSY) && !i2c_busy && (r_timer == C_TIMER_LAST);
    assign w_clear        = (w_finish || w_timeout) ? w_grant_onehot : '0;

    always_comb begin
        w_sel_addr = '0;
        w_sel_d0   = '0;
        w_sel_d1   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_idx == GRANT_W'(i)) begin
                w_sel_addr = r_slot_addr[i];
                w_sel_d0   = r_slot_d0[i];
                w_sel_d1   = r_slot_d1[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_done    <= '0;
            r_error   <= '0;
            r_addr    <= '0;
            r_d0      <= '0;
            r_d1      <= '0;
            r_start   <= 1'b0;
            r_grant   <= '0;
            r_ptr     <= C_PTR_RESET;
            r_timer   <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_slot_addr[i] <= '0;
                r_slot_d0[i]   <= '0;
                r_slot_d1[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_capture[i]) begin
                    r_slot_addr[i] <= req_address[I2C_ADDR_W*i +: I2C_ADDR_W];
                    r_slot_d0[i]   <= req_data_0[I2C_DATA_W*i +: I2C_DATA_W];
                    r_slot_d1[i]   <= req_data_1[I2C_DATA_W*i +: I2C_DATA_W];
                end
            end
            r_pending <= (r_pending | w_capture) & ~w_clear;
            r_done    <= w_clear;
            r_error   <= w_timeout ? w_grant_onehot : '0;
            r_start   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Hold off while the master is still finishing someone else's transfer.
                    if (w_pick_valid && !i2c_busy) begin
                        r_addr  <= w_sel_addr;
                        r_d0    <= w_sel_d0;
                        r_d1    <= w_sel_d1;
                        r_grant <= w_pick_idx;
                        r_ptr   <= w_pick_idx;
                        r_start <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (i2c_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i2c_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_busy    = r_pending;
    assign req_done    = r_done;
    assign req_error   = r_error;
    assign i2c_address = r_addr;
    assign i2c_data_0  = r_d0;
    assign i2c_data_1  = r_d1;
    assign i2c_start   = r_start;
    assign grant_id    = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_i2c_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_share_arbiter
//  Description : Self-checking bench with an I2C master responder and a
//                transaction-level round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_share_arbiter;
    import i2c_cfg_defs::*;

    localparam int NR  = 3;
    localparam int BWM = 8;

    logic                  clk;
    logic                  rst;
    logic [NR-1:0]         req_start;
    logic [7*NR-1:0]       req_address;
    logic [8*NR-1:0]       req_data_0;
    logic [8*NR-1:0]       req_data_1;
    logic [NR-1:0]         req_busy;
    logic [NR-1:0]         req_done;
    logic [NR-1:0]         req_error;
    logic                  i2c_busy;
    logic [6:0]            i2c_address;
    logic [7:0]            i2c_data_0;
    logic [7:0]            i2c_data_1;
    logic                  i2c_start;
    logic [2:0]            grant_id;

    i2c_share_arbiter #(
        .N_REQ         (NR),
        .BUSY_WAIT_MAX (BWM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_start   (req_start),
        .req_address (req_address),
        .req_data_0  (req_data_0),
        .req_data_1  (req_data_1),
        .req_busy    (req_busy),
        .req_done    (req_done),
        .req_error   (req_error),
        .i2c_busy    (i2c_busy),
        .i2c_address (i2c_address),
        .i2c_data_0  (i2c_data_0),
        .i2c_data_1  (i2c_data_1),
        .i2c_start   (i2c_start),
        .grant_id    (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model: one outstanding slot per requester, pointer = last grant.
    logic [NR-1:0] m_busy = '0;
    logic [6:0]    m_addr [NR];
    logic [7:0]    m_d0   [NR];
    logic [7:0]    m_d1   [NR];
    int            m_inflight  = -1;
    int            m_ptr       = NR - 1;
    bit            m_exp_err   = 1'b0;
    int            m_start_cyc = 0;
    int            done_cnt [NR];
    int            err_cnt   = 0;
    int            start_cnt = 0;
    int            aa_seen   = 0;
    int            q_grant [$];

    // Master responder configuration, sampled when it sees a start.
    int cfg_dly     = 3;
    int cfg_len     = 20;
    bit cfg_respond = 1'b1;
    int fall_cyc    = 0;
    bit mst_active  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor_step();
        logic [NR-1:0] acc;
        logic [NR-1:0] mask;
        int g;
        int idx;
        acc = req_start & ~m_busy;
        if (i2c_start === 1'b1) begin
            g = -1;
            for (int k = 1; k <= NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && m_busy[idx]) g = idx;
            end
            start_cnt++;
            check("start_legal", 32'((m_inflight < 0) && (g >= 0)), 32'd1);
            check("start_master_idle", 32'(i2c_busy), 32'd0);
            if (g >= 0) begin
                check("grant_id", 32'(grant_id), 32'(g));
                check("i2c_address", 32'(i2c_address), 32'(m_addr[g]));
                check("i2c_data_0", 32'(i2c_data_0), 32'(m_d0[g]));
                check("i2c_data_1", 32'(i2c_data_1), 32'(m_d1[g]));
                q_grant.push_back(g);
                m_ptr       = g;
                m_inflight  = g;
                m_start_cyc = cyc;
                m_exp_err   = !cfg_respond;
                if (i2c_data_0 == 8'hAA) aa_seen++;
            end
        end
        if ((req_done | req_error) !== '0) begin
            if (m_inflight >= 0) begin
                mask = '0;
                mask[m_inflight] = 1'b1;
                check("req_done_vec", 32'(req_done), 32'(mask));
                check("req_error_vec", 32'(req_error), 32'(m_exp_err ? mask : NR'(0)));
                check("done_cycle", 32'(cyc), 32'(m_exp_err ? m_start_cyc + BWM + 1 : fall_cyc + 1));
                done_cnt[m_inflight]++;
                if (m_exp_err) err_cnt++;
                m_busy[m_inflight] = 1'b0;
                m_inflight = -1;
            end else begin
                check("spurious_done", 32'({req_done, req_error}), 32'd0);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                m_busy[i] = 1'b1;
                m_addr[i] = req_address[7*i +: 7];
                m_d0[i]   = req_data_0[8*i +: 8];
                m_d1[i]   = req_data_1[8*i +: 8];
            end
        end
        check("req_busy", 32'(req_busy), 32'(m_busy));
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) monitor_step();
    end

    // I2C master: busy rises cfg_dly edges after start, stays cfg_len edges.
    initial begin
        int d;
        int l;
        i2c_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && i2c_start === 1'b1 && cfg_respond) begin
                d = cfg_dly;
                l = cfg_len;
                mst_active = 1'b1;
                repeat (d) @(posedge clk);
                #2 i2c_busy = 1'b1;
                repeat (l) @(posedge clk);
                #2 i2c_busy = 1'b0;
                fall_cyc   = cyc;
                mst_active = 1'b0;
            end
        end
    end

    task automatic set_slot(input int i, input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1);
        req_address[7*i +: 7] = a;
        req_data_0[8*i +: 8]  = d0;
        req_data_1[8*i +: 8]  = d1;
    endtask

    task automatic pulse(input logic [NR-1:0] m);
        @(negedge clk);
        req_start = m;
        @(negedge clk);
        req_start = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #2;
            if (m_busy == '0 && !mst_active && i2c_busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int issued;
        int dcnt;
        int ecnt;
        int scnt;
        bit seen;

        for (int i = 0; i < NR; i++) done_cnt[i] = 0;
        rst         = 1'b0;
        req_start   = '0;
        req_address = '0;
        req_data_0  = '0;
        req_data_1  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_busy", 32'(req_busy), 32'd0);
        check("rst_req_done", 32'(req_done), 32'd0);
        check("rst_req_error", 32'(req_error), 32'd0);
        check("rst_i2c_start", 32'(i2c_start), 32'd0);
        check("rst_i2c_address", 32'(i2c_address), 32'd0);
        check("rst_i2c_data_0", 32'(i2c_data_0), 32'd0);
        check("rst_i2c_data_1", 32'(i2c_data_1), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Contention: requester 0 served before 1 from reset priority
        set_slot(0, 7'h72, 8'h41, 8'h10);
        set_slot(1, 7'h1A, 8'h02, 8'h55);
        cfg_dly = 3; cfg_len = 6; cfg_respond = 1'b1;
        base = q_grant.size();
        scnt = start_cnt;
        pulse(3'b011);
        wait_drain("drain_contention", 200);
        check("contention_starts", 32'(start_cnt - scnt), 32'd2);
        if (q_grant.size() >= base + 2) begin
            check("contention_first", 32'(q_grant[base]), 32'd0);
            check("contention_second", 32'(q_grant[base+1]), 32'd1);
        end

        // Rotation: each requester re-requests on its own completion
        base   = q_grant.size();
        issued = 2;
        set_slot(0, 7'($urandom), 8'($urandom), 8'($urandom));
        set_slot(1, 7'($urandom), 8'($urandom), 8'($urandom));
        pulse(3'b011);
        for (int k = 0; k < 800 && issued < 6; k++) begin
            @(negedge clk);
            req_start = '0;
            for (int i = 0; i < 2; i++) begin
                if (req_done[i] && issued < 6) begin
                    set_slot(i, 7'($urandom), 8'($urandom), 8'($urandom));
                    req_start[i] = 1'b1;
                    issued++;
                end
            end
        end
        @(negedge clk);
        req_start = '0;
        wait_drain("drain_rotation", 300);
        check("rotation_count", 32'(q_grant.size() - base), 32'd6);
        if (q_grant.size() >= base + 6) begin
            for (int k = 0; k < 6; k++) check("rotation_order", 32'(q_grant[base+k]), 32'(k % 2));
        end

        // Single request with exact latency
        set_slot(0, HDMI_TX_ADDR, 8'h15, 8'h00);
        cfg_dly = 3; cfg_len = 20; cfg_respond = 1'b1;
        dcnt = done_cnt[0];
        @(negedge clk);
        req_start = 3'b001;
        @(posedge clk); #2;
        check("single_busy_E0", 32'(req_busy[0]), 32'd1);
        check("single_nostart_E0", 32'(i2c_start), 32'd0);
        @(negedge clk);
        req_start = '0;
        @(posedge clk); #2;
        check("single_start_E1", 32'(i2c_start), 32'd1);
        check("single_addr", 32'(i2c_address), 32'h72);
        check("single_d0", 32'(i2c_data_0), 32'h15);
        check("single_d1", 32'(i2c_data_1), 32'h00);
        check("single_grant", 32'(grant_id), 32'd0);
        @(posedge clk); #2;
        check("single_start_E2", 32'(i2c_start), 32'd0);
        wait_drain("drain_single", 200);
        check("single_done_count", 32'(done_cnt[0] - dcnt), 32'd1);
        check("single_hold_addr", 32'(i2c_address), 32'h72);

        // Ignore-while-busy: second request must never reach the master
        aa_seen = 0;
        dcnt    = done_cnt[0];
        set_slot(0, 7'h33, 8'h33, 8'h01);
        pulse(3'b001);
        repeat (5) @(negedge clk);
        set_slot(0, 7'h33, 8'hAA, 8'h02);
        pulse(3'b001);
        wait_drain("drain_ignore", 200);
        check("ignore_done_count", 32'(done_cnt[0] - dcnt), 32'd1);
        check("ignore_no_AA", 32'(aa_seen), 32'd0);

        // Timeout on requester 0, then pending requester 2 is issued
        base = q_grant.size();
        ecnt = err_cnt;
        cfg_respond = 1'b0;
        set_slot(0, 7'h10, 8'h20, 8'h30);
        set_slot(2, 7'h11, 8'h21, 8'h31);
        pulse(3'b001);
        @(negedge clk);
        cfg_respond = 1'b1;
        pulse(3'b100);
        wait_drain("drain_timeout", 200);
        check("timeout_err_count", 32'(err_cnt - ecnt), 32'd1);
        check("timeout_grants", 32'(q_grant.size() - base), 32'd2);
        if (q_grant.size() >= base + 2) check("timeout_next_grant", 32'(q_grant[base+1]), 32'd2);

        // Randomized traffic against the model
        scnt = start_cnt;
        dcnt = 0;
        for (int i = 0; i < NR; i++) dcnt -= done_cnt[i];
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            req_start = '0;
            for (int i = 0; i < NR; i++) begin
                set_slot(i, 7'($urandom), 8'($urandom), 8'($urandom));
                if ($urandom_range(0, 3) == 0) req_start[i] = 1'b1;
            end
            cfg_dly     = $urandom_range(1, 6);
            cfg_len     = $urandom_range(1, 12);
            cfg_respond = ($urandom_range(0, 5) != 0);
        end
        @(negedge clk);
        req_start   = '0;
        cfg_respond = 1'b1;
        wait_drain("drain_random", 1000);
        for (int i = 0; i < NR; i++) dcnt += done_cnt[i];
        check("random_start_vs_done", 32'(start_cnt - scnt), 32'(dcnt));

        // Reset while the master is mid-transfer
        cfg_dly = 2; cfg_len = 30; cfg_respond = 1'b1;
        set_slot(0, 7'h44, 8'h55, 8'h66);
        pulse(3'b001);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            if (i2c_busy) begin seen = 1'b1; break; end
        end
        check("mid_busy_rise", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        m_busy     = '0;
        m_inflight = -1;
        m_ptr      = NR - 1;
        #1;
        check("mid_rst_req_busy", 32'(req_busy), 32'd0);
        check("mid_rst_i2c_start", 32'(i2c_start), 32'd0);
        check("mid_rst_addr", 32'(i2c_address), 32'd0);
        check("mid_rst_d0", 32'(i2c_data_0), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        dcnt = done_cnt[1];
        base = q_grant.size();
        set_slot(1, 7'h5A, 8'h01, 8'h02);
        pulse(3'b010);
        @(posedge clk); #2;
        check("mid_wait_master", 32'({i2c_busy, i2c_start}), 32'b10);
        wait_drain("drain_after_reset", 300);
        check("mid_done_count", 32'(done_cnt[1] - dcnt), 32'd1);
        check("mid_grants", 32'(q_grant.size() - base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
